// File: rtl/dcm_clkgen_prog_if.sv
// Request/status and DCM programming signals of dcm_clkgen_prog, bundled.
// The master is the requester together with the DCM it drives.
// The slave is the programming controller.
interface dcm_clkgen_prog_if;
  logic       set_clk;
  logic [7:0] multi;
  logic [7:0] div;
  logic       progdone;
  logic       locked;
  logic       progen;
  logic       progdata;
  logic       busy;
  logic       rdy_clk;
  logic       err;

  modport master (
    output set_clk, multi, div, progdone, locked,
    input  progen, progdata, busy, rdy_clk, err
  );

  modport slave (
    input  set_clk, multi, div, progdone, locked,
    output progen, progdata, busy, rdy_clk, err
  );
endinterface

// File: rtl/dcm_clkgen_prog.sv
// dcm_clkgen_prog: serial reprogramming controller for a DCM_CLKGEN.
// It shifts out LoadD(div), LoadM(multi) and GO on PROGEN/PROGDATA.
// It then waits for PROGDONE and LOCKED, and pulses rdy_clk when the new
// frequency is locked.
// Optional watchdog: define OPTIMSOC_DCM_PROG_TIMEOUT_EN. Each wait state
// then gives up after TIMEOUT_CYCLES cycles, pulses err and returns to IDLE.
module dcm_clkgen_prog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk_buffered,
  input  logic               rst,
  dcm_clkgen_prog_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, LOAD_D, GAP_D, LOAD_M, GAP_M, GO, WAIT_DONE, WAIT_LOCK
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] multi_q, multi_d;
  logic [7:0] div_q, div_d;
  logic       progen_q, progen_d;
  logic       progdata_q, progdata_d;
  logic       err_q, err_d;
  logic [9:0] frame_dv, frame_mv;

`ifdef OPTIMSOC_DCM_PROG_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_expired;
  assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
  // Without the watchdog the timeout parameter has no effect.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Next-state, bit counter, operand latching and error-pulse logic.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    multi_d   = multi_q;
    div_d     = div_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.set_clk) begin
          if (bus.multi != 8'd0) begin
            state_d   = LOAD_D;
            bit_cnt_d = 4'd0;
            multi_d   = bus.multi;
            div_d     = bus.div;
          end else begin
            err_d = 1'b1;  // M=1 cannot be programmed
          end
        end
      end
      LOAD_D: begin
        if (bit_cnt_q == 4'd9) begin
          state_d   = GAP_D;
          bit_cnt_d = 4'd0;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      GAP_D: state_d = LOAD_M;
      LOAD_M: begin
        if (bit_cnt_q == 4'd9) begin
          state_d   = GAP_M;
          bit_cnt_d = 4'd0;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      GAP_M: state_d = GO;
      GO:    state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.progdone) begin
          state_d = WAIT_LOCK;
        end
`ifdef OPTIMSOC_DCM_PROG_TIMEOUT_EN
        else if (wd_expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
`endif
      end
      WAIT_LOCK: begin
        if (bus.locked) begin
          state_d = IDLE;
        end
`ifdef OPTIMSOC_DCM_PROG_TIMEOUT_EN
        else if (wd_expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // PROGEN/PROGDATA are registered, so they are derived from the state
  // and bit position the FSM is about to enter.
  always_comb begin
    progen_d   = 1'b0;
    progdata_d = 1'b0;
    frame_dv   = {div_d, 1'b0, 1'b1};    // first bits sent: 1, 0, then div LSB-first
    frame_mv   = {multi_d, 1'b1, 1'b1};  // first bits sent: 1, 1, then multi LSB-first
    case (state_d)
      LOAD_D: begin
        progen_d   = 1'b1;
        progdata_d = frame_dv[bit_cnt_d];
      end
      LOAD_M: begin
        progen_d   = 1'b1;
        progdata_d = frame_mv[bit_cnt_d];
      end
      GO: begin
        progen_d   = 1'b1;
        progdata_d = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef OPTIMSOC_DCM_PROG_TIMEOUT_EN
  // Watchdog clears on entry to a wait state and counts while it stays there.
  always_comb begin
    wd_d = '0;
    if ((state_q == WAIT_DONE || state_q == WAIT_LOCK) && state_d == state_q) begin
      wd_d = wd_q + 1'b1;
    end
  end
`endif

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_buffered) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      multi_q    <= 8'd0;
      div_q      <= 8'd0;
      progen_q   <= 1'b0;
      progdata_q <= 1'b0;
      err_q      <= 1'b0;
`ifdef OPTIMSOC_DCM_PROG_TIMEOUT_EN
      wd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      multi_q    <= multi_d;
      div_q      <= div_d;
      progen_q   <= progen_d;
      progdata_q <= progdata_d;
      err_q      <= err_d;
`ifdef OPTIMSOC_DCM_PROG_TIMEOUT_EN
      wd_q       <= wd_d;
`endif
    end
  end

  // busy and rdy_clk react to locked within the same cycle.
  // A reset in that cycle suppresses the ready pulse.
  assign bus.progen   = progen_q;
  assign bus.progdata = progdata_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state_q != IDLE) && !(state_q == WAIT_LOCK && bus.locked);
  assign bus.rdy_clk  = (state_q == WAIT_LOCK) && bus.locked && !rst;

endmodule
